// File: rtl/mouse_quad.sv
// Relative HID mouse deltas to Atari ST quadrature and button lines, drained one step per tick.
// Optional MOUSE_QUAD_ACCEL_EN doubles deltas with magnitude >= 16 before accumulation.
module mouse_quad #(
  parameter int unsigned STEP_DIV = 1600,
  parameter int unsigned ACC_W    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  input  logic [1:0] buttons,
  output logic [5:0] mouse,
  output logic       busy
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned D_W   = 9;
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [1:0]              ph_x_q, ph_x_d, ph_y_q, ph_y_d;
  logic [5:0]              mouse_q, mouse_d;
  logic                    busy_q, busy_d;
  logic                    tick_c;
  logic [1:0]              btn_d;

  function automatic logic signed [D_W-1:0] scale_delta(input logic [7:0] d);
    logic signed [D_W-1:0] d9;
    d9 = {d[7], d};
`ifdef MOUSE_QUAD_ACCEL_EN
    if (d9 >= 9'sd16 || d9 <= -9'sd16) d9 = d9 <<< 1;
`endif
    return d9;
  endfunction

  // Accumulate on strobe, retire one step on tick, saturate to the accumulator range.
  function automatic logic signed [ACC_W-1:0] next_acc(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [D_W-1:0]   d,
    input logic                    ld,
    input logic                    tk
  );
    logic signed [SUM_W-1:0] s;
    s = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
    if (ld) s = s + {{(SUM_W-D_W){d[D_W-1]}}, d};
    if (tk && acc != '0) s = acc[ACC_W-1] ? s + SUM_W'(1) : s - SUM_W'(1);
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [1:0] next_ph(
    input logic [1:0]              ph,
    input logic signed [ACC_W-1:0] acc,
    input logic                    tk
  );
    logic [1:0] p;
    p = ph;
    if (tk && acc != '0) p = acc[ACC_W-1] ? ph - 2'd1 : ph + 2'd1;
    return p;
  endfunction

  // Phase 0..3 -> {b, a} = 00, 01, 11, 10 (a leads b going forward).
  function automatic logic [1:0] enc(input logic [1:0] ph);
    return {ph[1], ph[1] ^ ph[0]};
  endfunction

  always_comb begin
    tick_c  = (tmr_q == TMR_LAST);
    tmr_d   = tick_c ? '0 : tmr_q + TMR_W'(1);
    acc_x_d = next_acc(acc_x_q, scale_delta(dx), strobe, tick_c);
    acc_y_d = next_acc(acc_y_q, scale_delta(dy), strobe, tick_c);
    ph_x_d  = next_ph(ph_x_q, acc_x_q, tick_c);
    ph_y_d  = next_ph(ph_y_q, acc_y_q, tick_c);
    btn_d   = strobe ? buttons : mouse_q[5:4];
    mouse_d = {btn_d, enc(ph_y_d), enc(ph_x_d)};
    busy_d  = (acc_x_d != '0) || (acc_y_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q   <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      ph_x_q  <= '0;
      ph_y_q  <= '0;
      mouse_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      tmr_q   <= tmr_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      ph_x_q  <= ph_x_d;
      ph_y_q  <= ph_y_d;
      mouse_q <= mouse_d;
      busy_q  <= busy_d;
    end
  end

  assign mouse = mouse_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mouse_quad.sv
// Directed bench for mouse_quad: vector table plus hand-written corner sequences.
module tb_mouse_quad;
  localparam int DIV = 8;
`ifdef MOUSE_QUAD_ACCEL_EN
  localparam int E20 = 40, EM16 = -32, EM128 = -256, E127 = 254;
`else
  localparam int E20 = 20, EM16 = -16, EM128 = -128, E127 = 127;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       strobe = 1'b0;
  logic [7:0] dx = '0, dy = '0;
  logic [1:0] buttons = '0;
  logic [5:0] mouse;
  logic       busy;

  mouse_quad #(.STEP_DIV(DIV), .ACC_W(12)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .dx(dx), .dy(dy),
    .buttons(buttons), .mouse(mouse), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int px = 0, py = 0, tmr_m = 0, illegal = 0;
  logic [1:0] prevx = '0, prevy = '0;

  function automatic logic [1:0] dec(input logic [1:0] m);
    return {m[1], m[0] ^ m[1]};
  endfunction

  // Quadrature decoder and step-timer model, sampled just after each rising edge.
  always @(posedge clk) begin
    logic [1:0] cx, cy, d;
    #1;
    if (reset) begin
      tmr_m = 0; px = 0; py = 0; prevx = '0; prevy = '0;
    end else begin
      tmr_m = (tmr_m == DIV - 1) ? 0 : tmr_m + 1;
      cx = dec(mouse[1:0]);
      cy = dec(mouse[3:2]);
      d = cx - prevx;
      if (d == 2'd1) px++; else if (d == 2'd3) px--; else if (d == 2'd2) illegal++;
      d = cy - prevy;
      if (d == 2'd1) py++; else if (d == 2'd3) py--; else if (d == 2'd2) illegal++;
      prevx = cx; prevy = cy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_strobe(input logic [7:0] x, input logic [7:0] y, input logic [1:0] b);
    dx = x; dy = y; buttons = b; strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0; dx = '0; dy = '0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_pos(input bit is_y, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if ((is_y ? py : px) == target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_tmr(input int target);
    for (int i = 0; i < 2 * DIV; i++) begin
      if (tmr_m == target) break;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
    int         ex;
    int         ey;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    int x0, y0, cnt_l, cnt_r;
    logic [1:0] exp_xab[3];
    logic [1:0] exp_yab[2];

    vecs[0] = '{8'sd3,    8'sd0,   2'b01, 3,     0};
    vecs[1] = '{8'sd0,    -8'sd2,  2'b10, 0,     -2};
    vecs[2] = '{8'sd20,   8'sd5,   2'b11, E20,   5};
    vecs[3] = '{8'sd15,   -8'sd16, 2'b00, 15,    EM16};
    vecs[4] = '{-8'sd7,   8'sd9,   2'b01, -7,    9};
    vecs[5] = '{8'sd0,    8'sd0,   2'b10, 0,     0};
    vecs[6] = '{8'h80,    8'sd127, 2'b00, EM128, E127};
    // Expected mouse[1:0] = {xb, xa} after steps 1..3 forward, mouse[3:2] after 2 steps back.
    exp_xab[0] = 2'b01; exp_xab[1] = 2'b11; exp_xab[2] = 2'b10;
    exp_yab[0] = 2'b10; exp_yab[1] = 2'b11;

    repeat (3) @(negedge clk);
    chk("reset_mouse", int'(mouse), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // dx=+3 from reset: a-leads-b sequence, busy drops with the third step.
    do_strobe(8'sd3, 8'sd0, 2'b00);
    chk("p3_busy_rise", int'(busy), 1);
    for (int i = 0; i < 3; i++) begin
      wait_pos(1'b0, i + 1, ok);
      chk("p3_step_seen", int'(ok), 1);
      chk("p3_xab", int'(mouse[1:0]), int'(exp_xab[i]));
      chk("p3_busy", int'(busy), (i < 2) ? 1 : 0);
    end
    chk("p3_y_quiet", int'(mouse[3:2]), 0);

    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    do_strobe(8'hFE, 8'sd0, 2'b00);
    do_strobe(8'sd0, -8'sd2, 2'b00);
    for (int i = 0; i < 2; i++) begin
      wait_pos(1'b1, -(i + 1), ok);
      chk("m2_step_seen", int'(ok), 1);
      chk("m2_yab", int'(mouse[3:2]), int'(exp_yab[i]));
    end

    // Table: one strobe per row, drain, compare net steps, buttons, busy.
    for (int r = 0; r < 7; r++) begin
      wait_idle(400 * DIV, ok);
      x0 = px; y0 = py;
      do_strobe(vecs[r].dx, vecs[r].dy, vecs[r].btn);
      wait_idle(300 * DIV, ok);
      chk($sformatf("vec%0d_idle", r), int'(ok), 1);
      chk($sformatf("vec%0d_x", r), px - x0, vecs[r].ex);
      chk($sformatf("vec%0d_y", r), py - y0, vecs[r].ey);
      chk($sformatf("vec%0d_btn", r), int'(mouse[5:4]), int'(vecs[r].btn));
    end

    // Strobe coincident with a tick while acc_x = 5.
    wait_tmr(0);
    x0 = px;
    do_strobe(8'sd5, 8'sd0, 2'b00);
    wait_tmr(DIV - 1);
    chk("coin_pre", px - x0, 0);
    do_strobe(8'sd4, 8'sd0, 2'b00);
    chk("coin_edge", px - x0, 1);
    wait_idle(30 * DIV, ok);
    chk("coin_total", px - x0, 9);

    // Buttons: left held for exactly 10 cycles between two strobes.
    cnt_l = 0; cnt_r = 0;
    do_strobe(8'sd0, 8'sd0, 2'b01);
    for (int i = 0; i < 20; i++) begin
      cnt_l += int'(mouse[4]);
      cnt_r += int'(mouse[5]);
      if (i == 9) do_strobe(8'sd0, 8'sd0, 2'b00);
      else @(negedge clk);
    end
    chk("btn_left_cycles", cnt_l, 10);
    chk("btn_right_cycles", cnt_r, 0);

    // Saturation in both directions.
    strobe = 1'b1; dx = 8'sd127;
    repeat (20) @(negedge clk);
    strobe = 1'b0; dx = '0;
    x0 = px;
    wait_idle(2100 * DIV, ok);
    chk("sat_pos_idle", int'(ok), 1);
    chk("sat_pos_steps", px - x0, 2047);
    strobe = 1'b1; dx = 8'h80;
    repeat (20) @(negedge clk);
    strobe = 1'b0; dx = '0;
    x0 = px;
    wait_idle(2100 * DIV, ok);
    chk("sat_neg_idle", int'(ok), 1);
    chk("sat_neg_steps", px - x0, -2048);

    // Reset after 2 of 10 steps discards the rest.
    x0 = px;
    do_strobe(8'sd10, 8'sd0, 2'b11);
    wait_pos(1'b0, x0 + 2, ok);
    chk("rst_mid_reached", int'(ok), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_mouse", int'(mouse), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    chk("rst_after_steps", px, 0);
    chk("rst_after_mouse", int'(mouse), 0);
    chk("rst_after_busy", int'(busy), 0);

    chk("no_double_jumps", illegal, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
